caterr_nmi_aggregator: RTL
==========================

# caterr_nmi_aggregator

Parametrised successor of the CPU error/NMI glue block: aggregates CATERR_N from NUM_CPU sockets through per-channel synchronisers and glitch filters, qualifies them with the CATERR filtering event, and generates the PCH crashlog trigger and BMC NMI routing. It adds a programmable delayed CATERR output (timer plus FSM) and a sticky first-fault source register for BMC readout. It sits in 19_MiscLogic alongside the other platform glue, clocked by the core CPLD system clock.

## Interface
- NUM_CPU, 2, number of CATERR_N inputs (1..8)
- GLITCH_CYCLES, 4, cycles a synchronised input must be stable before the filter output follows (>=1)
- DLY_COUNT, 1000, delayed-output timer length in iClk cycles (500 us at 2 MHz; >=2)
- iClk  in  1  system clock; one clock domain
- iRst_n  in  1  reset, synchronous, active-low
- iCpuCatErr_n  in  NUM_CPU  CPU CATERR_N pins, asynchronous, active-low
- iCatErrFilterEvent  in  1  high = CATERR qualified; low = CATERR masked
- iFmBmcCrashLogTrig_n  in  1  BMC crashlog trigger, active-low
- iFmGlbRstWarn_n  in  1  global reset warning, active-low
- iIrqBmcCpuNmi  in  1  BMC NMI request, active-high
- iBmcNmiPchEna  in  1  0 = BMC NMI to CPUs, 1 = BMC NMI to PCH
- iErrClr  in  1  one-cycle pulse, clears oCatErrSrc
- oCpuCatErr_n  out  1  qualified aggregate CATERR, active-low
- oCpuCatErrDly_n  out  1  aggregate CATERR delayed by DLY_COUNT, active-low
- oCatErrSrc  out  NUM_CPU  sticky first-fault sockets, active-high
- oFmPchCrashlogTrig_n  out  1  crashlog trigger to PCH, active-low
- oCpuNmi  out  1  NMI to CPUs
- oIrqBmcPchNmi  out  1  NMI to PCH

## Operation
- Per channel: 2-flop synchroniser, then filter register f[i]; f[i] takes the synchronised value after it has differed from f[i] for GLITCH_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
- oCpuCatErr_n = iCatErrFilterEvent ? &f : 1 (combinational from registers).
- oFmPchCrashlogTrig_n = oCpuCatErr_n ? iFmGlbRstWarn_n : iFmBmcCrashLogTrig_n.
- oCpuNmi = iBmcNmiPchEna ? 0 : iIrqBmcCpuNmi; oIrqBmcPchNmi = iBmcNmiPchEna ? iIrqBmcCpuNmi : 0. No PCH-to-CPU NMI path.
- Delay FSM, Moore, states IDLE, COUNT, ASSERT:
  - IDLE: oCpuCatErr_n==0 -> COUNT, counter cleared to 0.
  - COUNT: counter increments; continues even if oCpuCatErr_n returns high; at counter==DLY_COUNT-1 -> ASSERT.
  - ASSERT: oCpuCatErrDly_n=0; oCpuCatErr_n==1 -> IDLE. Minimum one cycle in ASSERT.
  - iCatErrFilterEvent low in any state -> IDLE next cycle, counter cleared (abort has priority).
- Counter width $clog2(DLY_COUNT); never exceeds DLY_COUNT-1, no wrap.
- oCatErrSrc: in the cycle FSM leaves IDLE, loads ~f (all sockets low then; simultaneous faults set multiple bits). Held until iErrClr. iErrClr has priority over a same-cycle load; after clear, reload only on the next IDLE->COUNT transition.

## Timing
- Reset: sync and filter flops 1, filter counters 0, FSM IDLE, delay counter 0, oCatErrSrc 0, oCpuCatErrDly_n 1, hence oCpuCatErr_n 1. Crashlog/NMI outputs follow inputs combinationally.
- Pin edge to f: 2 + GLITCH_CYCLES cycles.
- oCpuCatErr_n first low in cycle T -> COUNT at T+1 -> oCpuCatErrDly_n low from T+DLY_COUNT+1.
- Deassertion: oCpuCatErr_n high at T while in ASSERT -> oCpuCatErrDly_n high at T+1.
- iRst_n low mid-count: all state to reset values at next edge.

## Configuration
- CATERR_DLY_EN defined: delay FSM, counter, oCatErrSrc logic built as above.
- Undefined: no FSM/counter; oCpuCatErrDly_n tied 1, oCatErrSrc tied 0, iErrClr ignored; all other behaviour unchanged.

## Structure
- Package caterr_nmi_pkg: FSM state enum (IDLE, COUNT, ASSERT), 2-bit state encoding, sync depth localparam (2).
- Sub-module caterr_glitch_filter (synchroniser + stability counter, parameter GLITCH_CYCLES), instantiated NUM_CPU times via generate.

## Test plan
- NUM_CPU=2, GLITCH_CYCLES=4, DLY_COUNT=1000, filter event high; socket0 low at cycle 0 and held -> oCpuCatErr_n low at 6, oCpuCatErrDly_n low at 1007, oCatErrSrc=2'b01.
- 3-cycle low pulse on socket1 -> oCpuCatErr_n stays 1, FSM stays IDLE.
- Both sockets low same cycle, released 200 cycles later -> delayed output still asserts at +1001 for one cycle then high; oCatErrSrc=2'b11.
- iCatErrFilterEvent low at count 500 -> oCpuCatErr_n 1 immediately, FSM IDLE next cycle, oCpuCatErrDly_n never asserts.
- Crashlog/NMI: CATERR low, BMC trig 0 -> oFmPchCrashlogTrig_n 0; CATERR high, GlbRstWarn 0 -> 0; iBmcNmiPchEna 0/1 with iIrqBmcCpuNmi 1 -> oCpuNmi/oIrqBmcPchNmi = 1/0 then 0/1.
- iErrClr coincident with a new IDLE->COUNT -> oCatErrSrc 0; iRst_n low during ASSERT -> all outputs reset next edge.

Source files
------------

// File: rtl/caterr_nmi_pkg.sv
// Shared types for the CATERR/NMI aggregator: delay FSM state encoding and
// synchroniser depth.
package caterr_nmi_pkg;

  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COUNT  = 2'b01,
    ASSERT = 2'b10
  } dly_state_e;

endpackage

// File: rtl/caterr_glitch_filter.sv
// One CATERR_N channel: reset-to-high synchroniser followed by a filter that
// only follows the synchronised pin after GLITCH_CYCLES consecutive mismatches.
module caterr_glitch_filter
  import caterr_nmi_pkg::*;
#(
  parameter int unsigned GLITCH_CYCLES = 4
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iPin_n,
  output logic oFilt_n
);

  localparam int unsigned CW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GLITCH_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  filt_q, filt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sync_out;

  assign sync_out = sync_q[SYNC_DEPTH-1];

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], iPin_n};
    filt_d = filt_q;
    cnt_d  = '0;
    // The count tracks mismatch cycles already seen; the last one flips the filter.
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign oFilt_n = filt_q;

endmodule

// File: rtl/caterr_nmi_aggregator.sv
// CPU CATERR aggregation, crashlog trigger and BMC NMI routing. Defining
// CATERR_DLY_EN builds the delayed CATERR output and sticky first-fault register.
module caterr_nmi_aggregator
  import caterr_nmi_pkg::*;
#(
  parameter int unsigned NUM_CPU       = 2,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned DLY_COUNT     = 1000
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic [NUM_CPU-1:0] iCpuCatErr_n,
  input  logic               iCatErrFilterEvent,
  input  logic               iFmBmcCrashLogTrig_n,
  input  logic               iFmGlbRstWarn_n,
  input  logic               iIrqBmcCpuNmi,
  input  logic               iBmcNmiPchEna,
  input  logic               iErrClr,
  output logic               oCpuCatErr_n,
  output logic               oCpuCatErrDly_n,
  output logic [NUM_CPU-1:0] oCatErrSrc,
  output logic               oFmPchCrashlogTrig_n,
  output logic               oCpuNmi,
  output logic               oIrqBmcPchNmi
);

  logic [NUM_CPU-1:0] filt_n;
  logic               caterr_n;

  for (genvar i = 0; i < NUM_CPU; i++) begin : g_filt
    caterr_glitch_filter #(
      .GLITCH_CYCLES(GLITCH_CYCLES)
    ) u_filt (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iPin_n (iCpuCatErr_n[i]),
      .oFilt_n(filt_n[i])
    );
  end

  always_comb begin
    caterr_n             = iCatErrFilterEvent ? &filt_n : 1'b1;
    oCpuCatErr_n         = caterr_n;
    oFmPchCrashlogTrig_n = caterr_n ? iFmGlbRstWarn_n : iFmBmcCrashLogTrig_n;
    oCpuNmi              = iBmcNmiPchEna ? 1'b0 : iIrqBmcCpuNmi;
    oIrqBmcPchNmi        = iBmcNmiPchEna ? iIrqBmcCpuNmi : 1'b0;
  end

`ifdef CATERR_DLY_EN
  localparam int unsigned DW = $clog2(DLY_COUNT);
  localparam logic [DW-1:0] DLY_LAST = DW'(DLY_COUNT - 1);

  dly_state_e         state_q, state_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [NUM_CPU-1:0] src_q, src_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    src_d   = src_q;
    unique case (state_q)
      IDLE: begin
        dcnt_d = '0;
        if (!caterr_n) begin
          state_d = COUNT;
          src_d   = ~filt_n;
        end
      end
      COUNT: begin
        if (dcnt_q == DLY_LAST) begin
          state_d = ASSERT;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      ASSERT: begin
        if (caterr_n) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Masking the event aborts from any state; clear beats a same-cycle load.
    if (!iCatErrFilterEvent) begin
      state_d = IDLE;
      dcnt_d  = '0;
    end
    if (iErrClr) begin
      src_d = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      src_q   <= src_d;
    end
  end

  assign oCpuCatErrDly_n = (state_q != ASSERT);
  assign oCatErrSrc      = src_q;
`else
  logic unused_errclr;

  assign unused_errclr   = iErrClr;
  assign oCpuCatErrDly_n = 1'b1;
  assign oCatErrSrc      = '0;
`endif

endmodule
